// File: rtl/ins_fetcher_if.sv
// Instruction-fetch memory port.
//   master (fetcher): drives mem_req_valid/mem_req_addr, receives
//                     mem_req_ready, mem_resp_valid, mem_resp_data.
//   slave  (memory) : the mirror image.
interface ins_fetcher_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );
    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetcher: issues one word fetch at a time and buffers up to
// two {pc, ins} pairs for the decoder.
// Ports:
//   clk_in, rst_in          clock, synchronous active-low reset
//   rdy_in                  global ready, low freezes all state
//   ins_ready/ins/pc        FIFO head toward decoder (zero when empty)
//   IFetcher_stall          decoder holds the head
//   IFetcher_clear/new_addr redirect: flush and restart at new_addr
//   mem                     memory request/response port (master)
module ins_fetcher (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    output logic          ins_ready,
    output logic [31:0]   ins,
    output logic [31:0]   pc,
    input  logic          IFetcher_stall,
    input  logic          IFetcher_clear,
    input  logic [31:0]   IFetcher_new_addr,
    ins_fetcher_if.master mem
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [1:0]       count_q;
    logic             discard_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      inflight_pc_q;
    logic [1:0][31:0] fifo_pc_q;
    logic [1:0][31:0] fifo_ins_q;

    logic req_fire, resp_hit, push, pop;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^IFetcher_new_addr[1:0];

    assign req_fire = mem.mem_req_valid && mem.mem_req_ready;
    assign resp_hit = rdy_in && (state_q == WAIT) && mem.mem_resp_valid;
    // A clear drops the arriving word too; count guard makes overflow impossible.
    assign push     = resp_hit && !discard_q && !IFetcher_clear && (count_q != 2'd2);
    assign pop      = ins_ready && !IFetcher_stall && !IFetcher_clear && rdy_in;

    assign ins_ready = (count_q != 2'd0);
    assign pc        = ins_ready ? fifo_pc_q[0]  : 32'd0;
    assign ins       = ins_ready ? fifo_ins_q[0] : 32'd0;

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (!rst_in)     state_q <= IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    // FSM: next state (a clear while waiting keeps waiting; discard drops the word)
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = WAIT;
            WAIT:    if (mem.mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Request is held off while reset is asserted so the
    // port reads idle during reset.
    always_comb begin
        mem.mem_req_valid = rst_in && rdy_in && (state_q == IDLE) &&
                            (count_q < 2'd2) && !IFetcher_clear;
        mem.mem_req_addr  = fetch_pc_q;
    end

    // Datapath: fetch pointer, discard flag, 2-entry shift FIFO (entry 0 = head)
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q       <= 2'd0;
            discard_q     <= 1'b0;
            fetch_pc_q    <= 32'd0;
            inflight_pc_q <= 32'd0;
            fifo_pc_q     <= '0;
            fifo_ins_q    <= '0;
        end else if (rdy_in) begin
            if (IFetcher_clear) begin
                count_q    <= 2'd0;
                fetch_pc_q <= {IFetcher_new_addr[31:2], 2'b00};
                // Only a still-pending response needs to be swallowed later.
                discard_q  <= (state_q == WAIT) && !mem.mem_resp_valid;
            end else begin
                if (req_fire) begin
                    inflight_pc_q <= fetch_pc_q;
                    fetch_pc_q    <= fetch_pc_q + 32'd4;
                end
                if (resp_hit) discard_q <= 1'b0;
                case ({push, pop})
                    2'b10: begin
                        if (count_q == 2'd0) begin
                            fifo_pc_q[0]  <= inflight_pc_q;
                            fifo_ins_q[0] <= mem.mem_resp_data;
                        end else begin
                            fifo_pc_q[1]  <= inflight_pc_q;
                            fifo_ins_q[1] <= mem.mem_resp_data;
                        end
                        count_q <= count_q + 2'd1;
                    end
                    2'b01: begin
                        fifo_pc_q[0]  <= fifo_pc_q[1];
                        fifo_ins_q[0] <= fifo_ins_q[1];
                        count_q       <= count_q - 2'd1;
                    end
                    2'b11: begin
                        if (count_q == 2'd1) begin
                            fifo_pc_q[0]  <= inflight_pc_q;
                            fifo_ins_q[0] <= mem.mem_resp_data;
                        end else begin
                            fifo_pc_q[0]  <= fifo_pc_q[1];
                            fifo_ins_q[0] <= fifo_ins_q[1];
                            fifo_pc_q[1]  <= inflight_pc_q;
                            fifo_ins_q[1] <= mem.mem_resp_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher. Memory model: always ready, returns
// (addr ^ 0xDEAD0000) with mem_resp_valid high in the second cycle after
// acceptance; it freezes with rdy_in and resets with rst_in.
module tb_ins_fetcher;
    logic        clk, rst, rdy, stall, clear;
    logic [31:0] new_addr;
    logic        ins_ready;
    logic [31:0] ins, pc;
    int          total = 0;
    int          bad   = 0;

    ins_fetcher_if mif();

    ins_fetcher dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .ins_ready(ins_ready), .ins(ins), .pc(pc),
        .IFetcher_stall(stall), .IFetcher_clear(clear),
        .IFetcher_new_addr(new_addr), .mem(mif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        mcnt;
    logic [31:0] maddr;
    always @(posedge clk) begin
        if (!rst) begin
            mcnt <= 1'b0; maddr <= 32'd0;
            mif.mem_resp_valid <= 1'b0; mif.mem_resp_data <= 32'd0;
        end else if (rdy) begin
            mif.mem_resp_valid <= 1'b0;
            if (mcnt) begin
                mif.mem_resp_valid <= 1'b1;
                mif.mem_resp_data  <= maddr ^ 32'hDEAD_0000;
                mcnt <= 1'b0;
            end
            if (mif.mem_req_valid && mif.mem_req_ready) begin
                mcnt <= 1'b1; maddr <= mif.mem_req_addr;
            end
        end
    end

    // {ins_ready, pc, ins, mem_req_valid, mem_req_addr}
    function automatic logic [97:0] snap();
        return {ins_ready, pc, ins, mif.mem_req_valid, mif.mem_req_addr};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic stall_v);
        rst = 1'b0; clear = 1'b0; stall = stall_v; rdy = 1'b1; new_addr = 32'd0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [97:0] o;
        do_reset(1'b0);
        rst = 1'b0;
        tick();
        o = snap();
        total++; if (o !== 98'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", o); end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int got;
        do_reset(1'b0);
        tick();
        total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL stream_lat1 got=%b exp=0", ins_ready); end
        tick();
        total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL stream_lat2 got=%b exp=0", ins_ready); end
        tick();
        total++; if ({ins_ready, pc, ins} !== {1'b1, 32'h0, 32'hDEAD_0000}) begin
            bad++; $display("FAIL stream_first got=%b/%h/%h exp=1/0/dead0000", ins_ready, pc, ins); end
        exp_pc = 32'd4; got = 0;
        for (int i = 0; i < 40 && got < 6; i++) begin
            tick();
            if (ins_ready) begin
                total++; if ({pc, ins} !== {exp_pc, exp_pc ^ 32'hDEAD_0000}) begin
                    bad++; $display("FAIL stream_seq got=%h/%h exp=%h/%h", pc, ins, exp_pc, exp_pc ^ 32'hDEAD_0000); end
                exp_pc += 32'd4; got++;
            end
        end
        total++; if (got !== 6) begin bad++; $display("FAIL stream_count got=%0d exp=6", got); end
    endtask

    task automatic test_stall();
        logic [97:0] o;
        int unstable = 0;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ins_ready && pc !== 32'h0) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
        o = snap();
        total++; if (o !== {1'b1, 32'h0, 32'hDEAD_0000, 1'b0, 32'h8}) begin
            bad++; $display("FAIL stall_full got=%h exp=%h", o, {1'b1, 32'h0, 32'hDEAD_0000, 1'b0, 32'h8}); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        o = snap();
        total++; if (o !== {1'b1, 32'h4, 32'hDEAD_0004, 1'b1, 32'h8}) begin
            bad++; $display("FAIL stall_release got=%h exp=%h", o, {1'b1, 32'h4, 32'hDEAD_0004, 1'b1, 32'h8}); end
    endtask

    task automatic test_back_to_back();
        logic [97:0] o;
        logic found = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mif.mem_resp_valid && ins_ready) found = 1'b1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL b2b_wait got=%b exp=1", found); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        o = snap();
        total++; if (o !== {1'b1, 32'h4, 32'hDEAD_0004, 1'b1, 32'h8}) begin
            bad++; $display("FAIL b2b_pushpop got=%h exp=%h", o, {1'b1, 32'h4, 32'hDEAD_0004, 1'b1, 32'h8}); end
    endtask

    task automatic test_clear_wait();
        logic found = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mif.mem_req_valid && mif.mem_req_addr == 32'h8) found = 1'b1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL clrw_req8 got=%b exp=1", found); end
        tick();
        clear = 1'b1; new_addr = 32'h1002;
        #1;
        total++; if (mif.mem_req_valid !== 1'b0) begin bad++; $display("FAIL clrw_noreq got=%b exp=0", mif.mem_req_valid); end
        tick();
        clear = 1'b0;
        #1;
        total++; if ({ins_ready, mif.mem_req_valid} !== 2'b00) begin
            bad++; $display("FAIL clrw_flush got=%b exp=00", {ins_ready, mif.mem_req_valid}); end
        tick();
        total++; if ({ins_ready, mif.mem_req_valid, mif.mem_req_addr} !== {2'b01, 32'h1000}) begin
            bad++; $display("FAIL clrw_newreq got=%b%b/%h exp=01/00001000", ins_ready, mif.mem_req_valid, mif.mem_req_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ins_ready) found = 1'b1;
        end
        total++; if ({found, pc, ins} !== {1'b1, 32'h1000, 32'hDEAD_1000}) begin
            bad++; $display("FAIL clrw_head got=%b/%h/%h exp=1/00001000/dead1000", found, pc, ins); end
    endtask

    task automatic test_clear_resp();
        logic found = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mif.mem_resp_valid && ins_ready) found = 1'b1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL clrr_wait got=%b exp=1", found); end
        clear = 1'b1; new_addr = 32'h2000;
        tick();
        clear = 1'b0;
        #1;
        total++; if ({ins_ready, mif.mem_req_valid, mif.mem_req_addr} !== {2'b01, 32'h2000}) begin
            bad++; $display("FAIL clrr_newreq got=%b%b/%h exp=01/00002000", ins_ready, mif.mem_req_valid, mif.mem_req_addr); end
        stall = 1'b0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ins_ready) found = 1'b1;
        end
        stall = 1'b1;
        total++; if ({found, pc, ins} !== {1'b1, 32'h2000, 32'hDEAD_2000}) begin
            bad++; $display("FAIL clrr_head got=%b/%h/%h exp=1/00002000/dead2000", found, pc, ins); end
        for (int i = 0; i < 12; i++) tick();
        total++; if ({ins_ready, pc, mif.mem_req_valid} !== {1'b1, 32'h2000, 1'b0}) begin
            bad++; $display("FAIL clrf_full got=%b/%h/%b exp=1/00002000/0", ins_ready, pc, mif.mem_req_valid); end
        clear = 1'b1; new_addr = 32'h300;
        tick();
        clear = 1'b0;
        #1;
        total++; if ({ins_ready, mif.mem_req_valid, mif.mem_req_addr} !== {2'b01, 32'h300}) begin
            bad++; $display("FAIL clrf_newreq got=%b%b/%h exp=01/00000300", ins_ready, mif.mem_req_valid, mif.mem_req_addr); end
        stall = 1'b0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ins_ready) found = 1'b1;
        end
        stall = 1'b1;
        total++; if ({found, pc, ins} !== {1'b1, 32'h300, 32'hDEAD_0300}) begin
            bad++; $display("FAIL clrf_head got=%b/%h/%h exp=1/00000300/dead0300", found, pc, ins); end
    endtask

    task automatic test_wrap_rdy_rst();
        logic [97:0] o;
        do_reset(1'b1);
        clear = 1'b1; new_addr = 32'hFFFF_FFFE;
        tick();
        clear = 1'b0;
        #1;
        total++; if ({mif.mem_req_valid, mif.mem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", mif.mem_req_valid, mif.mem_req_addr); end
        tick(); tick(); tick();
        o = snap();
        total++; if (o !== {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b1, 32'h0}) begin
            bad++; $display("FAIL wrap_next got=%h exp=%h", o, {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b1, 32'h0}); end
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            o = snap();
            total++; if ({o, mif.mem_resp_valid} !== {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0, 32'h4, 1'b0}) begin
                bad++; $display("FAIL rdy_frozen got=%h/%b exp=%h/0", o, mif.mem_resp_valid, {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0, 32'h4}); end
        end
        rdy = 1'b1;
        tick(); tick();
        o = snap();
        total++; if (o !== {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0, 32'h4}) begin
            bad++; $display("FAIL rdy_resume_full got=%h exp=%h", o, {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0, 32'h4}); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        o = snap();
        total++; if (o !== {1'b1, 32'h0, 32'hDEAD_0000, 1'b1, 32'h4}) begin
            bad++; $display("FAIL rdy_resume_pop got=%h exp=%h", o, {1'b1, 32'h0, 32'hDEAD_0000, 1'b1, 32'h4}); end
        tick();
        rst = 1'b0;
        tick();
        o = snap();
        total++; if (o !== 98'd0) begin bad++; $display("FAIL rst_midwait got=%h exp=0", o); end
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.mem_req_ready = 1'b1;
        rst = 1'b0; rdy = 1'b1; stall = 1'b0; clear = 1'b0; new_addr = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_clear_wait();
        test_clear_resp();
        test_wrap_rdy_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ins_fetcher.md
INS_FETCHER -- requirements
Module: ins_fetcher

Interface
REQ-001 SHALL have ports: clk_in  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst_in  input  1  reset; synchronous, active-low.
REQ-003 SHALL have ports: rdy_in  input  1  global ready; low freezes all state.
REQ-004 SHALL have ports: ins_ready  output  1  head instruction valid toward decoder.
REQ-005 SHALL have ports: ins  output  32  head instruction word.
REQ-006 SHALL have ports: pc  output  32  address of head instruction.
REQ-007 SHALL have ports: IFetcher_stall  input  1  decoder cannot accept head this cycle.
REQ-008 SHALL have ports: IFetcher_clear  input  1  redirect request.
REQ-009 SHALL have ports: IFetcher_new_addr  input  32  redirect target.
REQ-010 SHALL have ports: mem_req_valid  output  1  word-fetch request.
REQ-011 SHALL have ports: mem_req_addr  output  32  word-fetch address, bits[1:0]=0.
REQ-012 SHALL have ports: mem_req_ready  input  1  memory controller accepts request.
REQ-013 SHALL have ports: mem_resp_valid  input  1  fetched word available, one-cycle pulse.
REQ-014 SHALL have ports: mem_resp_data  input  32  fetched word.

Function
REQ-015 SHALL keep a 2-entry FIFO of {pc, ins}, head driven combinationally onto pc/ins; ins_ready = (count != 0); pc/ins = 0 when empty.
REQ-016 SHALL implement FSM IDLE (no request outstanding) and WAIT (one request accepted, response pending); at most one outstanding request.
REQ-017 SHALL drive mem_req_valid = rdy_in && state==IDLE && count<2 && !IFetcher_clear; mem_req_addr = fetch_pc.
REQ-018 SHALL treat a request as accepted when mem_req_valid && mem_req_ready: inflight_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0), IDLE->WAIT.
REQ-019 SHALL, in WAIT on mem_resp_valid with discard=0, push {inflight_pc, mem_resp_data} and go IDLE; with discard=1, drop the word, clear discard, go IDLE.
REQ-020 SHALL pop the head when ins_ready && !IFetcher_stall && !IFetcher_clear && rdy_in; simultaneous push and pop keeps count unchanged and order preserved.
REQ-021 SHALL, when IFetcher_clear=1: flush FIFO (count <= 0), fetch_pc <= {IFetcher_new_addr[31:2],2'b00}, set discard <= 1 if state==WAIT (response not yet arrived), no pop that cycle.
REQ-022 SHALL, on clear coinciding with mem_resp_valid, drop that response and go IDLE with discard=0.
REQ-023 SHALL never push when count==2; since requests require count<2 and no pop-free path adds more than one in-flight word, overflow is unreachable.
REQ-024 SHALL, when rdy_in=0, hold all registers and ignore mem_resp_valid (memory controller shares rdy_in and produces no responses while low).
REQ-025 SHALL have latency: word presented on ins the cycle after mem_resp_valid; next request may issue that same cycle if count<2.

Reset
REQ-026 SHALL, while rst_in=0 at a clock edge, set state=IDLE, count=0, discard=0, fetch_pc=0x00000000, inflight_pc=0, FIFO contents 0; hence ins_ready=0, ins=0, pc=0, mem_req_valid=0, mem_req_addr=0.
REQ-027 SHALL abandon any outstanding request on reset; a response arriving in the first cycle after reset (state IDLE) is ignored.

Verification
REQ-028 SHALL cover: reset, memory returns word k at addr 4k with 2-cycle latency, stall=0 -> ins/pc sequence 0x0,0x4,0x8... in order, no gaps or duplicates.
REQ-029 SHALL cover: stall held high 10 cycles -> count reaches 2, mem_req_valid=0, head stays pc=0x0 stable; release -> pops 0x0 then 0x4.
REQ-030 SHALL cover: clear with new_addr=0x1002 while WAIT on addr 0x8 -> response for 0x8 dropped, next request addr 0x1000, next ins_ready shows pc=0x1000.
REQ-031 SHALL cover: clear coinciding with mem_resp_valid and with a full FIFO -> FIFO empties, response discarded, discard=0, request to new target next cycle.
REQ-032 SHALL cover: fetch_pc=0xFFFFFFFC -> following request addr 0x00000000; rdy_in low mid-WAIT for 5 cycles -> all outputs frozen, resumes correctly; rst_in low mid-WAIT -> reset values next cycle.
